// File: rtl/score_text_ctrl.sv
// Score banner text source: converts the binary score to BCD with an iterative
// double-dabble, commits digits and mode only during vertical blanking, and
// serves registered ASCII codes for the overlay's character lookups.
module score_text_ctrl #(
    parameter int SCORE_W   = 14,
    parameter int TEXT_LEN  = 14,
    parameter int SCORE_MAX = 9999
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    input  logic               game_over_in,
    input  logic               victory_in,
    input  logic               vblnk_in,
    input  logic [7:0]         char_yx,
    output logic [6:0]         char_code,
    output logic               busy,
    output logic [1:0]         mode_out
);
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [SCORE_W-1:0] SAT_VAL  = SCORE_W'(SCORE_MAX);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCORE_W - 1);

    // Banner prefixes, leftmost character in the top byte.
    localparam logic [8*9-1:0] TXT_PLAY = "    SCORE";
    localparam logic [8*9-1:0] TXT_OVER = "GAME OVER";
    localparam logic [8*9-1:0] TXT_WIN  = "  YOU WIN";

    typedef enum logic [1:0] {IDLE, CONV, WAIT, COMMIT} state_t;

    state_t             state, state_nxt;
    logic [SCORE_W-1:0] bin_q;
    logic [15:0]        bcd_q;
    logic [15:0]        disp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pend_vld;
    logic [SCORE_W-1:0] pend_score;
    logic               start_load;
    logic [SCORE_W-1:0] load_val;
    logic [6:0]         code_nxt;

    function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] v);
        return (v > SAT_VAL) ? SAT_VAL : v;
    endfunction

    // Add 3 to every nibble >= 5 before the shift.
    function automatic logic [15:0] dabble(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++)
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] banner(input logic [1:0] m, input logic [3:0] c);
        int idx;
        idx = 8 - int'(c);
        case (m)
            2'd1:    return TXT_OVER[idx*8 +: 7];
            2'd2:    return TXT_WIN[idx*8 +: 7];
            default: return TXT_PLAY[idx*8 +: 7];
        endcase
    endfunction

    // A strobe in COMMIT is newer than anything pending, so it is taken directly.
    assign start_load = (state == IDLE && score_valid) ||
                        (state == COMMIT && (score_valid || pend_vld));
    assign load_val   = (state == COMMIT && !score_valid) ? pend_score : score_in;
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (score_valid) state_nxt = CONV;
            CONV:    if (cnt_q == CNT_LAST) state_nxt = WAIT;
            WAIT:    if (vblnk_in) state_nxt = COMMIT;
            COMMIT:  state_nxt = start_load ? CONV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble datapath: load saturated score, then one adjust+shift per cycle.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start_load) begin
            bin_q <= saturate(load_val);
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (state == CONV) begin
            {bcd_q, bin_q} <= {dabble(bcd_q), bin_q} << 1;
            cnt_q          <= cnt_q + 1'b1;
        end
    end

    // One-deep pending slot; latest strobe while busy wins, consumed on restart.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld   <= 1'b0;
            pend_score <= '0;
        end else if (state == COMMIT) begin
            if (start_load) pend_vld <= 1'b0;
        end else if (state != IDLE && score_valid) begin
            pend_vld   <= 1'b1;
            pend_score <= score_in;
        end
    end

    // Commit digits and mode; game over beats victory on a tie.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q   <= '0;
            mode_out <= 2'd0;
        end else if (state == COMMIT) begin
            disp_q   <= bcd_q;
            mode_out <= game_over_in ? 2'd1 : (victory_in ? 2'd2 : 2'd0);
        end
    end

    // Character lookup from committed state only.
    always_comb begin
        code_nxt = 7'h20;
        if (char_yx[7:4] == 4'd0 && int'(char_yx[3:0]) < TEXT_LEN) begin
            case (char_yx[3:0])
                4'd9:    code_nxt = 7'h20;
                4'd10:   code_nxt = {3'b011, disp_q[15:12]};
                4'd11:   code_nxt = {3'b011, disp_q[11:8]};
                4'd12:   code_nxt = {3'b011, disp_q[7:4]};
                4'd13:   code_nxt = {3'b011, disp_q[3:0]};
                default: code_nxt = banner(mode_out, char_yx[3:0]);
            endcase
        end
    end

    // Registered font-ROM code, one cycle behind char_yx.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) char_code <= 7'h20;
        else        char_code <= code_nxt;
    end
endmodule

// File: tb/tb_score_text_ctrl.sv
// Directed bench for score_text_ctrl: reset, conversion, saturation, mode
// priority, pending coalescing and reset abort.
module tb_score_text_ctrl;
    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] score_in = '0;
    logic        score_valid = 1'b0;
    logic        game_over_in = 1'b0;
    logic        victory_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [7:0]  char_yx = '0;
    logic [6:0]  char_code;
    logic        busy;
    logic [1:0]  mode_out;

    int checks = 0;
    int errors = 0;

    logic mon_on = 1'b0;
    logic seen1 = 1'b0, seen2 = 1'b0, seen3 = 1'b0, order_bad = 1'b0;

    score_text_ctrl dut (
        .pclk(pclk), .rst_n(rst_n), .score_in(score_in), .score_valid(score_valid),
        .game_over_in(game_over_in), .victory_in(victory_in), .vblnk_in(vblnk_in),
        .char_yx(char_yx), .char_code(char_code), .busy(busy), .mode_out(mode_out)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [7:0] yx, input logic [6:0] exp);
        @(negedge pclk) char_yx = yx;
        @(negedge pclk) chk(tag, 32'(char_code), 32'(exp));
    endtask

    task automatic strobe(input logic [13:0] v);
        @(negedge pclk) begin score_in = v; score_valid = 1'b1; end
        @(negedge pclk) score_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin @(negedge pclk); n++; end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic digits(input string tag, input logic [6:0] d3, d2, d1, d0);
        look({tag, "_d3"}, 8'h0A, d3);
        look({tag, "_d2"}, 8'h0B, d2);
        look({tag, "_d1"}, 8'h0C, d1);
        look({tag, "_d0"}, 8'h0D, d0);
    endtask

    // Tens-digit monitor for the coalescing test.
    always @(negedge pclk) begin
        if (mon_on) begin
            if (char_code == 7'h31) seen1 <= 1'b1;
            if (char_code == 7'h32) seen2 <= 1'b1;
            if (char_code == 7'h33) begin
                seen3 <= 1'b1;
                if (!seen1) order_bad <= 1'b1;
            end
        end
    end

    initial begin
        int nb;
        // T1 reset
        repeat (3) @(negedge pclk);
        chk("rst_code", 32'(char_code), 32'h20);
        rst_n = 1'b1;
        @(negedge pclk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mode", 32'(mode_out), 0);
        for (int i = 0; i < 4; i++) look("rst_blank", 8'(i), 7'h20);
        look("rst_S", 8'h04, 7'h53);
        look("rst_col9", 8'h09, 7'h20);
        digits("rst", 7'h30, 7'h30, 7'h30, 7'h30);

        // T2 score 42 held off by vblank
        strobe(14'd42);
        chk("s42_busy", 32'(busy), 1);
        repeat (40) @(negedge pclk);
        chk("s42_wait_busy", 32'(busy), 1);
        look("s42_hold_d1", 8'h0C, 7'h30);
        look("s42_hold_d0", 8'h0D, 7'h30);
        vblnk_in = 1'b1;
        wait_idle("s42_idle");
        digits("s42", 7'h30, 7'h30, 7'h34, 7'h32);

        // T3 saturation, zero, max with busy length
        strobe(14'd12345);
        wait_idle("s12345_idle");
        digits("sat", 7'h39, 7'h39, 7'h39, 7'h39);
        strobe(14'd0);
        wait_idle("s0_idle");
        digits("zero", 7'h30, 7'h30, 7'h30, 7'h30);
        nb = 0;
        @(negedge pclk) begin score_in = 14'd9999; score_valid = 1'b1; end
        @(negedge pclk) score_valid = 1'b0;
        while (busy && nb < 100) begin nb++; @(negedge pclk); end
        chk("s9999_busy_cycles", 32'(nb), 32'd16);
        digits("max", 7'h39, 7'h39, 7'h39, 7'h39);

        // T4 mode priority
        game_over_in = 1'b1; victory_in = 1'b1;
        strobe(14'd5);
        wait_idle("go_idle");
        chk("go_mode", 32'(mode_out), 1);
        look("go_G", 8'h00, 7'h47);
        look("go_R", 8'h08, 7'h52);
        game_over_in = 1'b0;
        strobe(14'd6);
        wait_idle("win_idle");
        chk("win_mode", 32'(mode_out), 2);
        look("win_Y", 8'h02, 7'h59);
        look("win_sp", 8'h00, 7'h20);
        victory_in = 1'b0;
        strobe(14'd7);
        wait_idle("play_idle");
        chk("play_mode", 32'(mode_out), 0);
        look("play_S", 8'h04, 7'h53);

        // T5 pending coalescing: 10, then 20 and 30 while busy
        @(negedge pclk) char_yx = 8'h0C;
        @(negedge pclk) mon_on = 1'b1;
        strobe(14'd10);
        repeat (2) @(negedge pclk);
        strobe(14'd20);
        strobe(14'd30);
        wait_idle("coal_idle");
        repeat (2) @(negedge pclk);
        mon_on = 1'b0;
        chk("coal_seen10", 32'(seen1), 1);
        chk("coal_seen30", 32'(seen3), 1);
        chk("coal_no20", 32'(seen2), 0);
        chk("coal_order", 32'(order_bad), 0);
        digits("coal", 7'h30, 7'h30, 7'h33, 7'h30);

        // T6 reset mid-conversion
        vblnk_in = 1'b0;
        strobe(14'd77);
        repeat (4) @(negedge pclk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_code", 32'(char_code), 32'h20);
        @(negedge pclk) rst_n = 1'b1;
        vblnk_in = 1'b1;
        repeat (30) @(negedge pclk);
        chk("abort_busy_late", 32'(busy), 0);
        chk("abort_mode", 32'(mode_out), 0);
        digits("abort", 7'h30, 7'h30, 7'h30, 7'h30);
        look("oor_row1", 8'h10, 7'h20);
        look("oor_col14", 8'h0E, 7'h20);
        look("oor_col15", 8'h0F, 7'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
